ibex_fetch_req_ctrl: RTL and testbench

- Instruction-side bus request sequencer that sits between the IF stage and the instruction memory port.
- Issues word-aligned fetch requests, tracks up to NUM_REQS outstanding transactions and discards responses that belong to a superseded stream after a branch.
- Pushes accepted responses, with their error flags, into the fetch FIFO.
- Generates the FIFO clear and restart address on every branch.

---
 rtl/ibex_fetch_pkg.sv | 22 ++
 rtl/ibex_fetch_outstanding_trk.sv | 65 ++++++
 rtl/ibex_fetch_req_ctrl.sv | 149 ++++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ibex_fetch_pkg
// Shared constants and types for the instruction fetch request sequencer.
//   FETCH_NUM_REQS   default number of outstanding bus transactions
//   FETCH_ADDR_INCR  byte increment between consecutive fetch words
//   DISCARD_CNT_W    width of the optional discarded-response counter
//   req_vec_t        outstanding/discard vector type for the default depth
//   word_align()     clears the byte offset of an address
// ----------------------------------------------------------------------------
package ibex_fetch_pkg;

   localparam int unsigned FETCH_NUM_REQS  = 2;
   localparam logic [31:0] FETCH_ADDR_INCR = 32'd4;
   localparam int unsigned DISCARD_CNT_W   = 16;

   typedef logic [FETCH_NUM_REQS-1:0] req_vec_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ibex_fetch_outstanding_trk.sv
// ----------------------------------------------------------------------------
// ibex_fetch_outstanding_trk
// Tracks granted-but-unanswered bus transactions as a thermometer vector
// (bit 0 is the oldest) with a parallel discard vector marking responses
// that belong to a superseded fetch stream.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   gnt                a request was granted this cycle
//   rvalid             the oldest transaction responds this cycle
//   branch             fetch redirect: mark everything still outstanding
//   new_discard        the transaction granted this cycle is stale
//   outstanding_head   at least one transaction is outstanding
//   discard_head       the oldest outstanding response must be dropped
//   full               NUM_REQS transactions outstanding
// ----------------------------------------------------------------------------
module ibex_fetch_outstanding_trk #(
   parameter int unsigned NUM_REQS = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic gnt,
   input  logic rvalid,
   input  logic branch,
   input  logic new_discard,
   output logic outstanding_head,
   output logic discard_head,
   output logic full
);

   logic [NUM_REQS-1:0] outstanding_q;
   logic [NUM_REQS-1:0] discard_q;
   logic [NUM_REQS-1:0] outstanding_shift;
   logic [NUM_REQS-1:0] discard_shift;
   logic [NUM_REQS-1:0] set_vec;

   // A response retires the oldest entry before a same-cycle grant claims
   // the lowest free slot, so the vector always stays a thermometer code.
   always_comb begin
      outstanding_shift = rvalid ? (outstanding_q >> 1) : outstanding_q;
      discard_shift     = rvalid ? (discard_q >> 1) : discard_q;
      set_vec           = '0;
      if (gnt) begin
         set_vec = ~outstanding_shift & {outstanding_shift[NUM_REQS-2:0], 1'b1};
      end
   end

   // A branch poisons every entry that survives this cycle; the newly granted
   // entry is poisoned only when it was the stale held request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_shift | set_vec;
         discard_q     <= discard_shift
                        | (branch ? outstanding_shift : '0)
                        | (new_discard ? set_vec : '0);
      end
   end

   assign outstanding_head = outstanding_q[0];
   assign discard_head     = discard_q[0];
   assign full             = outstanding_q[NUM_REQS-1];

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// ----------------------------------------------------------------------------
// ibex_fetch_req_ctrl
// Instruction-side bus request sequencer between the IF stage and the
// instruction memory port. Issues word-aligned fetches, keeps at most
// NUM_REQS transactions in flight, drops responses of superseded streams
// after a branch and pushes the remaining responses into the fetch FIFO.
// Optional feature macro: IBEX_FETCH_DISCARD_CNT_EN enables a saturating
// 16-bit count of dropped responses on discard_cnt_o (tied to 0 otherwise).
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_i                          IF stage wants instructions
//   branch_i, branch_addr_i        single-cycle redirect and its target
//   busy_o                         request pending or response outstanding
//   instr_req_o/gnt_i/addr_o       bus request channel
//   instr_rvalid_i/rdata_i/err_i   bus response channel
//   fifo_clear_o, fifo_addr_o      FIFO flush and restart address
//   fifo_valid_o/rdata_o/err_o     FIFO push
//   fifo_ready_i                   FIFO can take NUM_REQS more entries
//   discard_cnt_o                  dropped-response count
// ----------------------------------------------------------------------------
module ibex_fetch_req_ctrl
   import ibex_fetch_pkg::*;
#(
   parameter int unsigned NUM_REQS = FETCH_NUM_REQS
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_i,
   input  logic                     branch_i,
   input  logic [31:0]              branch_addr_i,
   output logic                     busy_o,
   output logic                     instr_req_o,
   input  logic                     instr_gnt_i,
   output logic [31:0]              instr_addr_o,
   input  logic                     instr_rvalid_i,
   input  logic [31:0]              instr_rdata_i,
   input  logic                     instr_err_i,
   output logic                     fifo_clear_o,
   output logic                     fifo_valid_o,
   input  logic                     fifo_ready_i,
   output logic [31:0]              fifo_addr_o,
   output logic [31:0]              fifo_rdata_o,
   output logic                     fifo_err_o,
   output logic [DISCARD_CNT_W-1:0] discard_cnt_o
);

   logic        req_pending_q;
   logic        branch_stored_q;
   logic [31:0] fetch_addr_q;
   logic [31:0] stored_addr_q;
   logic [31:0] branch_target;
   logic        outstanding_head;
   logic        discard_head;
   logic        full;
   logic        req_valid;
   logic        gnt_accept;
   logic        new_discard;

   assign branch_target = word_align(branch_addr_i);

   // A held request always wins; a new one needs FIFO room and a free slot.
   // Outputs are forced low while reset is asserted so the bus sees silence.
   assign req_valid    = req_pending_q | (req_i & fifo_ready_i & ~full);
   assign instr_req_o  = rst_ni & req_valid;
   assign gnt_accept   = instr_req_o & instr_gnt_i;
   assign instr_addr_o = (branch_i & ~req_pending_q) ? branch_target : fetch_addr_q;

   // The held request is stale if a branch arrived while it waited.
   assign new_discard  = req_pending_q & (branch_i | branch_stored_q);

   ibex_fetch_outstanding_trk #(
      .NUM_REQS (NUM_REQS)
   ) u_outstanding_trk (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .gnt              (gnt_accept),
      .rvalid           (instr_rvalid_i),
      .branch           (branch_i),
      .new_discard      (new_discard),
      .outstanding_head (outstanding_head),
      .discard_head     (discard_head),
      .full             (full)
   );

   // fetch_addr_q must stay frozen while a request is held; a branch that
   // lands during the hold is parked in stored_addr_q and becomes the next
   // fetch address once the held request is granted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_pending_q   <= 1'b0;
         branch_stored_q <= 1'b0;
         fetch_addr_q    <= '0;
         stored_addr_q   <= '0;
      end else begin
         req_pending_q <= instr_req_o & ~instr_gnt_i;
         if (req_pending_q) begin
            if (instr_gnt_i) begin
               branch_stored_q <= 1'b0;
               if (branch_i) begin
                  fetch_addr_q <= branch_target;
               end else if (branch_stored_q) begin
                  fetch_addr_q <= stored_addr_q;
               end else begin
                  fetch_addr_q <= fetch_addr_q + FETCH_ADDR_INCR;
               end
            end else if (branch_i) begin
               branch_stored_q <= 1'b1;
               stored_addr_q   <= branch_target;
            end
         end else if (branch_i) begin
            fetch_addr_q <= branch_target + (gnt_accept ? FETCH_ADDR_INCR : 32'd0);
         end else if (gnt_accept) begin
            fetch_addr_q <= fetch_addr_q + FETCH_ADDR_INCR;
         end
      end
   end

   assign fifo_clear_o = rst_ni & branch_i;
   assign fifo_addr_o  = branch_addr_i;
   assign fifo_valid_o = rst_ni & instr_rvalid_i & ~discard_head;
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign busy_o       = instr_req_o | outstanding_head;

`ifdef IBEX_FETCH_DISCARD_CNT_EN
   logic [DISCARD_CNT_W-1:0] discard_cnt_q;

   // Saturating count of responses dropped because of a redirect.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         discard_cnt_q <= '0;
      end else if (instr_rvalid_i & discard_head & ~(&discard_cnt_q)) begin
         discard_cnt_q <= discard_cnt_q + 1'b1;
      end
   end

   assign discard_cnt_o = discard_cnt_q;
`else
   assign discard_cnt_o = '0;
`endif

`ifndef SYNTHESIS
   // A response can only answer a transaction that was granted earlier.
   rvalid_needs_outstanding : assert property (
      @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> outstanding_head
   );
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ibex_fetch_req_ctrl
// Self-checking bench for ibex_fetch_req_ctrl: a table of directed vectors,
// a hand-written asynchronous reset sequence and a randomized run compared
// against a transaction-level reference model (queue of in-flight fetches).
// ----------------------------------------------------------------------------
module tb_ibex_fetch_req_ctrl;

   localparam int NUM_REQS = 2;

   logic        clock = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        busy_o;
   logic        instr_req_o;
   logic        instr_gnt_i;
   logic [31:0] instr_addr_o;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;
   logic        fifo_clear_o;
   logic        fifo_valid_o;
   logic        fifo_ready_i;
   logic [31:0] fifo_addr_o;
   logic [31:0] fifo_rdata_o;
   logic        fifo_err_o;
   logic [15:0] discard_cnt_o;

   int checks = 0;
   int errors = 0;

   // Free-running clock, rising edge is the active edge.
   always #5 clock = ~clock;

   ibex_fetch_req_ctrl #(
      .NUM_REQS (NUM_REQS)
   ) dut (
      .clk_i          (clock),
      .rst_ni         (rst_ni),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .branch_addr_i  (branch_addr_i),
      .busy_o         (busy_o),
      .instr_req_o    (instr_req_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_addr_o   (instr_addr_o),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .fifo_clear_o   (fifo_clear_o),
      .fifo_valid_o   (fifo_valid_o),
      .fifo_ready_i   (fifo_ready_i),
      .fifo_addr_o    (fifo_addr_o),
      .fifo_rdata_o   (fifo_rdata_o),
      .fifo_err_o     (fifo_err_o),
      .discard_cnt_o  (discard_cnt_o)
   );

   typedef struct {
      logic        req;
      logic        branch;
      logic [31:0] baddr;
      logic        gnt;
      logic        rvalid;
      logic        err;
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_fvalid;
      logic        exp_busy;
      logic        exp_clear;
   } vec_t;

   vec_t vecs[$];

   // Compares one observed value to the value the bench worked out itself.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle's worth of inputs (blocking, from the negative edge).
   task automatic applyStimulus(input logic req, input logic br, input logic [31:0] baddr,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic err, input logic ready);
      req_i          = req;
      branch_i       = br;
      branch_addr_i  = baddr;
      instr_gnt_i    = gnt;
      instr_rvalid_i = rv;
      instr_rdata_i  = rdata;
      instr_err_i    = err;
      fifo_ready_i   = ready;
   endtask

   function automatic vec_t mk(input logic req, input logic br, input logic [31:0] baddr,
                               input logic gnt, input logic rv, input logic err, input logic ready,
                               input logic exp_req, input logic [31:0] exp_addr,
                               input logic exp_fvalid, input logic exp_busy, input logic exp_clear);
      vec_t v;
      v.req = req; v.branch = br; v.baddr = baddr; v.gnt = gnt; v.rvalid = rv;
      v.err = err; v.ready = ready; v.exp_req = exp_req; v.exp_addr = exp_addr;
      v.exp_fvalid = exp_fvalid; v.exp_busy = exp_busy; v.exp_clear = exp_clear;
      return v;
   endfunction

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      rst_ni = 1'b0;
      repeat (2) @(negedge clock);
      rst_ni = 1'b1;
   endtask

   // Reference model state: one queue entry per in-flight fetch, holding its
   // discard flag, plus the address stream bookkeeping.
   bit          m_disc[$];
   logic [31:0] m_fetch;
   bit          m_pending;
   bit          m_stored;
   logic [31:0] m_stored_addr;
   int          m_cnt;

   initial begin
      logic [31:0] rd;
      logic [31:0] exp_cnt;
      rst_ni = 1'b1;
      doReset();

      // Reset values.
      #1;
      checkOutput("reset_req", instr_req_o, 0);
      checkOutput("reset_busy", busy_o, 0);
      checkOutput("reset_fvalid", fifo_valid_o, 0);
      checkOutput("reset_clear", fifo_clear_o, 0);
      checkOutput("reset_addr", instr_addr_o, 0);
      checkOutput("reset_cnt", discard_cnt_o, 0);

      //        req br baddr      gnt rv err rdy  ereq eaddr       efv ebusy eclr
      // streaming with a grant every cycle
      vecs.push_back(mk(1, 0, 0,         1, 0, 0, 1,  1, 32'h000, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 1, 0, 1,  1, 32'h004, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 1, 0, 1,  1, 32'h008, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0, 1,  0, 32'h00C, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0, 1,  0, 32'h00C, 0, 0, 0));
      // grant withheld, branch to 0x102 during the hold
      vecs.push_back(mk(1, 0, 0,         0, 0, 0, 1,  1, 32'h00C, 0, 1, 0));
      vecs.push_back(mk(1, 1, 32'h102,   0, 0, 0, 1,  1, 32'h00C, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0, 0,  1, 32'h00C, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         1, 0, 0, 1,  1, 32'h00C, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,         0, 1, 0, 1,  1, 32'h100, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         1, 0, 0, 1,  1, 32'h100, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0, 1,  0, 32'h104, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0, 1,  0, 32'h104, 0, 0, 0));
      // fill both slots, request drops until the first response
      vecs.push_back(mk(1, 0, 0,         1, 0, 0, 1,  1, 32'h104, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 0, 0, 1,  1, 32'h108, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 0, 0, 1,  0, 32'h10C, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 1, 0, 1,  0, 32'h10C, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 0, 0, 1,  1, 32'h10C, 0, 1, 0));
      // branch to 0x200 with two outstanding: both responses dropped
      vecs.push_back(mk(1, 1, 32'h200,   1, 0, 0, 1,  0, 32'h200, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0,         1, 1, 0, 1,  0, 32'h200, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 1, 0, 1,  1, 32'h200, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0, 1,  0, 32'h204, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0, 1,  0, 32'h204, 0, 0, 0));
      // FIFO not ready: no new request; error response still pushed
      vecs.push_back(mk(1, 0, 0,         1, 0, 0, 1,  1, 32'h204, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 1, 1, 0,  0, 32'h208, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0,         1, 0, 0, 0,  0, 32'h208, 0, 0, 0));
      // held request completes even after the FIFO fills
      vecs.push_back(mk(1, 0, 0,         0, 0, 0, 1,  1, 32'h208, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         1, 0, 0, 0,  1, 32'h208, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0, 0,  0, 32'h20C, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0, 1,  0, 32'h20C, 0, 0, 0));
      // branch coinciding with a grant: target fetched and kept
      vecs.push_back(mk(1, 1, 32'h302,   1, 0, 0, 1,  1, 32'h300, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0,         0, 1, 0, 1,  0, 32'h304, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,         0, 0, 0, 1,  0, 32'h304, 0, 0, 0));

      foreach (vecs[i]) begin
         @(negedge clock);
         rd = 32'hD000_0000 | i;
         applyStimulus(vecs[i].req, vecs[i].branch, vecs[i].baddr, vecs[i].gnt,
                       vecs[i].rvalid, rd, vecs[i].err, vecs[i].ready);
         #1;
         checkOutput($sformatf("v%0d_req", i), instr_req_o, vecs[i].exp_req);
         checkOutput($sformatf("v%0d_addr", i), instr_addr_o, vecs[i].exp_addr);
         checkOutput($sformatf("v%0d_fvalid", i), fifo_valid_o, vecs[i].exp_fvalid);
         checkOutput($sformatf("v%0d_busy", i), busy_o, vecs[i].exp_busy);
         checkOutput($sformatf("v%0d_clear", i), fifo_clear_o, vecs[i].exp_clear);
         if (vecs[i].exp_fvalid) begin
            checkOutput($sformatf("v%0d_rdata", i), fifo_rdata_o, rd);
            checkOutput($sformatf("v%0d_err", i), fifo_err_o, vecs[i].err);
         end
         if (vecs[i].exp_clear) begin
            checkOutput($sformatf("v%0d_faddr", i), fifo_addr_o, vecs[i].baddr);
         end
      end

      // Three responses were dropped in the table above.
`ifdef IBEX_FETCH_DISCARD_CNT_EN
      exp_cnt = 3;
`else
      exp_cnt = 0;
`endif
      @(negedge clock);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      checkOutput("table_discard_cnt", discard_cnt_o, exp_cnt);

      // Asynchronous reset with one outstanding and one pending request.
      @(negedge clock);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
      #1;
      checkOutput("rst_seq_addr0", instr_addr_o, 32'h304);
      @(negedge clock);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clock);
      applyStimulus(1, 0, 0, 0, 1, 32'h1234, 0, 1);
      #1;
      checkOutput("rst_seq_pending", instr_req_o, 1);
      #1;
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_async_req", instr_req_o, 0);
      checkOutput("rst_async_busy", busy_o, 0);
      checkOutput("rst_async_fvalid", fifo_valid_o, 0);
      checkOutput("rst_async_clear", fifo_clear_o, 0);
      checkOutput("rst_async_cnt", discard_cnt_o, 0);
      @(negedge clock);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      rst_ni = 1'b1;
      repeat (2) begin
         @(negedge clock);
         #1;
         checkOutput("post_rst_idle_req", instr_req_o, 0);
         checkOutput("post_rst_idle_busy", busy_o, 0);
      end
      @(negedge clock);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
      #1;
      checkOutput("post_rst_addr", instr_addr_o, 32'h0);
      checkOutput("post_rst_req", instr_req_o, 1);

      // Randomized run against the reference model.
      @(negedge clock);
      doReset();
      m_disc.delete();
      m_fetch = 0; m_pending = 0; m_stored = 0; m_stored_addr = 0; m_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        req, br, gnt, rv, err, ready;
         logic [31:0] baddr, target, rdata, eaddr, ecnt;
         logic        ereq, efv, front_disc;
         if (cyc != 0) @(negedge clock);
         req   = ($urandom_range(0, 3) != 0);
         ready = ($urandom_range(0, 4) != 0);
         br    = ($urandom_range(0, 9) == 0);
         baddr = $urandom & 32'hFFFF_FFFE;
         gnt   = $urandom_range(0, 1) != 0;
         rv    = (m_disc.size() > 0) && ($urandom_range(0, 1) != 0);
         rdata = $urandom;
         err   = ($urandom_range(0, 7) == 0);
         applyStimulus(req, br, baddr, gnt, rv, rdata, err, ready);
         target     = baddr & 32'hFFFF_FFFC;
         front_disc = (m_disc.size() > 0) ? m_disc[0] : 1'b0;
         ereq  = m_pending || (req && ready && (m_disc.size() < NUM_REQS));
         eaddr = (br && !m_pending) ? target : m_fetch;
         efv   = rv && !front_disc;
`ifdef IBEX_FETCH_DISCARD_CNT_EN
         ecnt = m_cnt;
`else
         ecnt = 0;
`endif
         #1;
         checkOutput("rnd_req", instr_req_o, ereq);
         if (ereq) checkOutput("rnd_addr", instr_addr_o, eaddr);
         checkOutput("rnd_fvalid", fifo_valid_o, efv);
         if (efv) begin
            checkOutput("rnd_rdata", fifo_rdata_o, rdata);
            checkOutput("rnd_err", fifo_err_o, err);
         end
         checkOutput("rnd_busy", busy_o, ereq || (m_disc.size() > 0));
         checkOutput("rnd_clear", fifo_clear_o, br);
         if (br) checkOutput("rnd_faddr", fifo_addr_o, baddr);
         checkOutput("rnd_cnt", discard_cnt_o, ecnt);

         @(posedge clock);
         if (rv) begin
            if (front_disc && m_cnt < 65535) m_cnt++;
            void'(m_disc.pop_front());
         end
         if (br) foreach (m_disc[k]) m_disc[k] = 1'b1;
         if (ereq && gnt) begin
            m_disc.push_back(m_pending && (br || m_stored));
            if (m_pending) begin
               m_fetch  = br ? target : (m_stored ? m_stored_addr : m_fetch + 4);
               m_stored = 0;
            end else begin
               m_fetch = (br ? target : m_fetch) + 4;
            end
            m_pending = 0;
         end else if (ereq) begin
            if (m_pending && br) begin
               m_stored      = 1;
               m_stored_addr = target;
            end else if (!m_pending && br) begin
               m_fetch = target;
            end
            m_pending = 1;
         end else if (br) begin
            m_fetch = target;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
